draw_bullet: RTL and testbench

//  Downstream stage of the tank generator: consumes its delayed VGA timing, rgb and mouse position.
//  On a fire request, launches a shell from the tank centre toward the latched mouse target.

---
 rtl/bullet_pkg.sv | 22 ++
 rtl/bullet_step.sv | 29 ++
 rtl/draw_bullet.sv | 183 ++++++++++++++++++
 tb/tb_draw_bullet.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared definitions for the shell overlay stage.
//   state_e       : controller states (IDLE, FLY, BURST)
//   *_DEF         : default screen size and overlay colours
//   clamp_coord() : limits a coordinate to the last visible pixel
package bullet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLY   = 2'd1,
    BURST = 2'd2
  } state_e;

  localparam int          H_RES_DEF     = 800;
  localparam int          V_RES_DEF     = 600;
  localparam logic [11:0] SHELL_RGB_DEF = 12'hFF0;
  localparam logic [11:0] BURST_RGB_DEF = 12'hF00;

  function automatic logic [11:0] clamp_coord(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bullet_step.sv
// One-axis move of the shell toward its target, saturated at STEP pixels.
//   pos_i : current coordinate (12-bit unsigned)
//   tgt_i : target coordinate  (12-bit unsigned)
//   nxt_o : coordinate after one frame of movement
module bullet_step #(
  parameter int STEP = 4
) (
  input  logic [11:0] pos_i,
  input  logic [11:0] tgt_i,
  output logic [11:0] nxt_o
);

  localparam logic signed [12:0] STEP_S = 13'(STEP);

  logic signed [12:0] diff;

  always_comb begin
    // Zero-extend both operands so the 13-bit difference keeps its sign.
    diff = $signed({1'b0, tgt_i}) - $signed({1'b0, pos_i});
    if (diff > STEP_S) begin
      nxt_o = pos_i + 12'(STEP);
    end else if (diff < -STEP_S) begin
      nxt_o = pos_i - 12'(STEP);
    end else begin
      nxt_o = tgt_i;
    end
  end

endmodule

// File: rtl/draw_bullet.sv
// Shell overlay stage following the tank generator. A fire rising edge in
// IDLE launches a shell from the tank centre toward the clamped mouse target;
// the shell moves once per frame (on the vblank rising edge), is drawn as a
// small square, and on arrival turns into an impact square for BURST_FRAMES
// frames.
//   clk, rst                    : pixel clock, async active-low reset
//   hcount_in..vblnk_in, rgb_in : incoming VGA timing and colour
//   tank_x/y, target_x/y        : launch point and target, sampled at launch
//   fire                        : level fire request (rising edge used)
//   hcount_out..vblnk_out       : timing delayed by one clock
//   rgb_out                     : composited colour, aligned with timing outputs
//   busy                        : shell or burst active
//   hit                         : one-clock pulse on arrival
//   state_dbg                   : current controller state
module draw_bullet
  import bullet_pkg::*;
#(
  parameter int          H_RES        = H_RES_DEF,
  parameter int          V_RES        = V_RES_DEF,
  parameter int          STEP         = 4,
  parameter int          SHELL_SZ     = 4,
  parameter int          BURST_SZ     = 16,
  parameter int          BURST_FRAMES = 20,
  parameter logic [11:0] SHELL_RGB    = SHELL_RGB_DEF,
  parameter logic [11:0] BURST_RGB    = BURST_RGB_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [11:0] tank_x,
  input  logic [11:0] tank_y,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  input  logic        fire,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        busy,
  output logic        hit,
  output logic [1:0]  state_dbg
);

  localparam int                 CNT_W      = $clog2(BURST_FRAMES + 1);
  localparam logic signed [13:0] SHELL_HALF = 14'(SHELL_SZ / 2);
  localparam logic signed [13:0] BURST_HALF = 14'(BURST_SZ / 2);

  state_e             state_q;
  logic [11:0]        pos_x_q, pos_y_q, tgt_x_q, tgt_y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hit_q, vblnk_q, fire_q;
  logic               tick, fire_edge, arrive;
  logic [11:0]        nxt_x, nxt_y;

  logic [10:0]        hcount_q;
  logic [9:0]         vcount_q;
  logic               hsync_q, vsync_q, hblnk_q, vblnk_out_q;
  logic [11:0]        rgb_q, rgb_d;

  logic signed [13:0] half, x_lo, x_hi, y_lo, y_hi, h_s, v_s;
  logic               in_win;

  assign tick      = vblnk_in & ~vblnk_q;
  assign fire_edge = fire & ~fire_q;

  bullet_step #(.STEP(STEP)) u_step_x (.pos_i(pos_x_q), .tgt_i(tgt_x_q), .nxt_o(nxt_x));
  bullet_step #(.STEP(STEP)) u_step_y (.pos_i(pos_y_q), .tgt_i(tgt_y_q), .nxt_o(nxt_y));

  assign arrive = (nxt_x == tgt_x_q) && (nxt_y == tgt_y_q);

  // Controller: position only changes on a frame tick so a shell never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pos_x_q <= '0;
      pos_y_q <= '0;
      tgt_x_q <= '0;
      tgt_y_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      vblnk_q <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      fire_q  <= fire;
      hit_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A coincident tick is deliberately not used: load only.
          if (fire_edge) begin
            pos_x_q <= tank_x;
            pos_y_q <= tank_y;
            tgt_x_q <= clamp_coord(target_x, 12'(H_RES - 1));
            tgt_y_q <= clamp_coord(target_y, 12'(V_RES - 1));
            cnt_q   <= '0;
            state_q <= FLY;
          end
        end
        FLY: begin
          if (tick) begin
            pos_x_q <= nxt_x;
            pos_y_q <= nxt_y;
            if (arrive) begin
              state_q <= BURST;
              hit_q   <= 1'b1;
            end
          end
        end
        BURST: begin
          if (tick) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BURST_FRAMES - 1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Window test in signed arithmetic so a square near an edge clips instead
  // of wrapping to the opposite side of the screen.
  always_comb begin
    half   = (state_q == BURST) ? BURST_HALF : SHELL_HALF;
    x_lo   = $signed({2'b00, pos_x_q}) - half;
    x_hi   = $signed({2'b00, pos_x_q}) + half - 14'sd1;
    y_lo   = $signed({2'b00, pos_y_q}) - half;
    y_hi   = $signed({2'b00, pos_y_q}) + half - 14'sd1;
    h_s    = $signed({3'b000, hcount_in});
    v_s    = $signed({4'b0000, vcount_in});
    in_win = (state_q != IDLE) && (h_s >= x_lo) && (h_s <= x_hi) &&
             (v_s >= y_lo) && (v_s <= y_hi);
    if (hblnk_in || vblnk_in) begin
      rgb_d = 12'h000;
    end else if (in_win) begin
      rgb_d = (state_q == BURST) ? BURST_RGB : SHELL_RGB;
    end else begin
      rgb_d = rgb_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblnk_q     <= 1'b0;
      vblnk_out_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      hcount_q    <= hcount_in;
      vcount_q    <= vcount_in;
      hsync_q     <= hsync_in;
      vsync_q     <= vsync_in;
      hblnk_q     <= hblnk_in;
      vblnk_out_q <= vblnk_in;
      rgb_q       <= rgb_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign hblnk_out  = hblnk_q;
  assign vblnk_out  = vblnk_out_q;
  assign rgb_out    = rgb_q;
  assign busy       = (state_q != IDLE);
  assign hit        = hit_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_draw_bullet.sv
module tb_draw_bullet;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, tank_x, tank_y, target_x, target_y;
  logic        fire;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic        busy, hit;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int hits_seen = 0;
  logic hit_flag;
  logic [36:0] exp_q[$];

  // Reference model state
  int   m_state, m_px, m_py, m_tx, m_ty, m_cnt;
  logic m_hit, m_vb, m_fp;

  always #5 clk = ~clk;

  draw_bullet dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .tank_x(tank_x), .tank_y(tank_y),
    .target_x(target_x), .target_y(target_y),
    .fire(fire),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out),
    .busy(busy), .hit(hit), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    m_state = 0; m_px = 0; m_py = 0; m_tx = 0; m_ty = 0; m_cnt = 0;
    m_hit = 1'b0; m_vb = 1'b0; m_fp = 1'b0;
  endtask

  function automatic logic [11:0] model_rgb();
    int s, h, v;
    if (hblnk_in || vblnk_in) return 12'h000;
    if (m_state == 0) return rgb_in;
    s = (m_state == 2) ? 16 : 4;
    h = int'(hcount_in);
    v = int'(vcount_in);
    if (h >= m_px - s / 2 && h <= m_px + s / 2 - 1 && v >= m_py - s / 2 && v <= m_py + s / 2 - 1)
      return (m_state == 2) ? 12'hF00 : 12'hFF0;
    return rgb_in;
  endfunction

  function automatic int move_axis(input int p, input int t);
    if (t - p > 4) return p + 4;
    if (p - t > 4) return p - 4;
    return t;
  endfunction

  task automatic model_update();
    logic tk, fe;
    tk = vblnk_in && !m_vb;
    fe = fire && !m_fp;
    m_hit = 1'b0;
    if (m_state == 0) begin
      if (fe) begin
        m_px = int'(tank_x); m_py = int'(tank_y);
        m_tx = (int'(target_x) > 799) ? 799 : int'(target_x);
        m_ty = (int'(target_y) > 599) ? 599 : int'(target_y);
        m_cnt = 0; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (tk) begin
        m_px = move_axis(m_px, m_tx);
        m_py = move_axis(m_py, m_ty);
        if (m_px == m_tx && m_py == m_ty) begin
          m_state = 2; m_hit = 1'b1;
        end
      end
    end else begin
      if (tk) begin
        m_cnt++;
        if (m_cnt == 20) m_state = 0;
      end
    end
    m_vb = vblnk_in;
    m_fp = fire;
  endtask

  // One clock: push expected output, advance model, sample 1 time unit after the edge.
  task automatic step();
    logic [36:0] got_v, exp_v;
    exp_q.push_back({hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, model_rgb()});
    model_update();
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    check("pipe", 40'(got_v), 40'(exp_v));
    check("busy", 40'(busy), 40'(m_state != 0));
    check("hit", 40'(hit), 40'(m_hit));
    if (hit === 1'b1) begin
      hits_seen++;
      hit_flag = 1'b1;
    end
  endtask

  task automatic tick();
    vblnk_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1;
    step();
    vblnk_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0;
    step();
  endtask

  // Probe one visible pixel and compare against a fixed colour, or against rgb_in.
  task automatic check_px(input string tag, input int h, input int v, input logic use_in,
                          input logic [11:0] col);
    logic [11:0] px;
    px = 12'h123 + 12'($urandom_range(0, 255));
    hblnk_in = 1'b0; vblnk_in = 1'b0;
    hcount_in = 11'(h); vcount_in = 10'(v); rgb_in = px;
    hsync_in = 1'($urandom_range(0, 1));
    step();
    check(tag, 40'(rgb_out), 40'(use_in ? px : col));
  endtask

  task automatic run_to_hit(input int max, output int n);
    n = 0;
    hit_flag = 1'b0;
    while (!hit_flag && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy === 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic launch(input int tx, input int ty, input int gx, input int gy);
    tank_x = 12'(tx); tank_y = 12'(ty); target_x = 12'(gx); target_y = 12'(gy);
    fire = 1'b1;
    step();
    fire = 1'b0;
    step();
  endtask

  initial begin
    int n, h0;
    reset_model();
    rst = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd7; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = 12'hABC;
    tank_x = '0; tank_y = '0; target_x = '0; target_y = '0; fire = 1'b0;
    hit_flag = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 40'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                             rgb_out, busy, hit, state_dbg}), 40'd0);
    rst = 1'b1;
    vsync_in = 1'b0;
    for (int i = 0; i < 4; i++) check_px("idle_pass", $urandom_range(0, 799), $urandom_range(0, 599), 1'b1, 12'h0);
    hblnk_in = 1'b1;
    step();
    check("blank_rgb", 40'(rgb_out), 40'd0);
    hblnk_in = 1'b0;

    // Straight flight along x: 100 -> 120 in 5 ticks
    launch(100, 100, 120, 100);
    check("busy_fly", 40'(busy), 40'd1);
    tick();
    check_px("fly_x104", 104, 100, 1'b0, 12'hFF0);
    check_px("fly_x106_out", 106, 100, 1'b1, 12'h0);
    h0 = hits_seen;
    run_to_hit(20, n);
    check("ticks_to_hit", 40'(n), 40'd4);
    check("one_hit", 40'(hits_seen - h0), 40'd1);
    check_px("burst_ctr", 120, 100, 1'b0, 12'hF00);
    check_px("burst_lo", 112, 92, 1'b0, 12'hF00);
    check_px("burst_hi", 127, 107, 1'b0, 12'hF00);
    check_px("burst_out", 128, 100, 1'b1, 12'h0);
    wait_idle(40, n);
    check("burst_frames", 40'(n), 40'd20);
    check_px("after_burst", 120, 100, 1'b1, 12'h0);

    // Fire edge during flight is ignored
    launch(100, 200, 140, 200);
    h0 = hits_seen;
    tick();
    fire = 1'b1;
    tick();
    check_px("ign_x108", 108, 200, 1'b0, 12'hFF0);
    fire = 1'b0;
    run_to_hit(20, n);
    check("ign_ticks", 40'(n), 40'd8);
    check("ign_one_hit", 40'(hits_seen - h0), 40'd1);
    wait_idle(40, n);

    // Clamped target at the bottom-right corner
    launch(790, 590, 2000, 700);
    run_to_hit(20, n);
    check("clamp_ticks", 40'(n), 40'd3);
    check_px("clamp_ctr", 799, 599, 1'b0, 12'hF00);
    check_px("clamp_lo", 791, 591, 1'b0, 12'hF00);
    check_px("clamp_xout", 790, 599, 1'b1, 12'h0);
    check_px("clamp_yout", 799, 590, 1'b1, 12'h0);
    check_px("nowrap_x0", 0, 599, 1'b1, 12'h0);
    check_px("nowrap_00", 0, 0, 1'b1, 12'h0);
    wait_idle(40, n);
    check("clamp_idle", 40'(busy), 40'd0);

    // Fire coincident with a tick, target == tank
    tank_x = 12'd300; tank_y = 12'd300; target_x = 12'd300; target_y = 12'd300;
    fire = 1'b1; vblnk_in = 1'b1; hblnk_in = 1'b1;
    step();
    vblnk_in = 1'b0; hblnk_in = 1'b0;
    step();
    check("coinc_busy", 40'(busy), 40'd1);
    check("coinc_state", 40'(state_dbg), 40'd1);
    check_px("coinc_lo", 298, 298, 1'b0, 12'hFF0);
    check_px("coinc_hi", 301, 301, 1'b0, 12'hFF0);
    check_px("coinc_out_l", 297, 300, 1'b1, 12'h0);
    check_px("coinc_out_r", 302, 300, 1'b1, 12'h0);
    fire = 1'b0;
    run_to_hit(5, n);
    check("coinc_ticks", 40'(n), 40'd1);
    wait_idle(40, n);

    // Reset mid-flight
    launch(100, 100, 200, 100);
    tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_outs", 40'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                              rgb_out, busy, hit}), 40'd0);
    reset_model();
    exp_q.delete();
    rst = 1'b1;
    check_px("midrst_gone", 104, 100, 1'b1, 12'h0);
    check("midrst_busy", 40'(busy), 40'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
